foc_seq: RTL
============

# foc_seq

Parametrised control-loop sequencer for the FOC datapath. It accepts one sample per `valid`/`ready` handshake and raises a capture strobe. It then starts `NUM_STAGES` compute stages strictly in order (cordic/clarke, park, PID, ipark, iclarke, svm, …), each through a start/done handshake, and finishes each loop with a timed soft-reset of the datapath. Compared with the fixed sequencer it adds per-stage watchdog timeout, fault latch/clear, overrun counting and loop-latency measurement.

## Interface
- `NUM_STAGES`, 6, number of sequenced stages (2..16)
- `TIMEOUT`, 512, max cycles a stage may take before fault (≥2)
- `RST_CYC`, 1, cycles `mod_rstb` is held low at end of loop (≥1)
- `CNT_W`, 16, width of `loop_cycles`
- `clk`  in  1  clock
- `rstb`  in  1  reset, asynchronous, active-low
- `valid`  in  1  new sample available
- `ready`  out  1  sequencer idle, sample accepted when `valid && ready`
- `cap_en`  out  1  one-cycle strobe: datapath input registers load
- `stage_start`  out  NUM_STAGES  one-hot start pulse to stage k
- `stage_done`  in  NUM_STAGES  level/pulse done from stage k; tie high for fixed-latency stages
- `mod_rstb`  out  1  active-low soft reset to datapath stages
- `loop_done`  out  1  one-cycle pulse, loop completed without fault
- `loop_cycles`  out  CNT_W  cycles from accept to `loop_done`, latched, saturating
- `overrun_cnt`  out  8  saturating count of dropped samples
- `fault`  out  1  watchdog fault latched
- `fault_stage`  out  $clog2(NUM_STAGES)  index of timed-out stage
- `fault_clr`  in  1  clears fault, returns to IDLE

## Operation
- All outputs registered. Reset values: `ready`=1, `mod_rstb`=1, all others 0; state IDLE, stage index 0.
- IDLE: `ready`=1. On `valid`: `cap_en`=1 next cycle, `ready`→0, idx=0, cycle counter=1, go to START.
- START: `stage_start[idx]`=1 for this cycle only, timer=0, go to WAIT.
- WAIT: `stage_done[idx]` is sampled from the cycle after START. If done and idx=NUM_STAGES-1, go to FLUSH. If done otherwise, idx++ and go to START. If timer reaches TIMEOUT-1 without done, go to FAULT and latch `fault_stage`=idx. Done wins over a same-cycle timeout. `stage_done` bits of other stages are ignored.
- FLUSH: `mod_rstb`=0 for exactly RST_CYC cycles. On the next cycle: `mod_rstb`=1, `loop_done`=1, `ready`=1, `loop_cycles` latched, state IDLE.
- FAULT: `fault`=1, `mod_rstb`=0 held, `ready`=0. On `fault_clr`: `fault`=0, `mod_rstb`=1, `ready`=1, state IDLE. No `loop_done`. `fault_stage` is kept until the next fault.
- Overrun: each cycle with `valid && !ready`, `overrun_cnt`++ (saturates at 255) and the sample is dropped. `valid` on the same cycle `ready` rises is accepted normally.
- Cycle counter saturates at 2^CNT_W-1.
- `rstb` asserted mid-loop: immediate return to reset values. No flush pulse is generated.

## Timing
- Accept at T0. `stage_start[k]` at T(1+2k) when every done is immediate.
- Minimum loop with immediate dones: `loop_done` at T(2·NUM_STAGES+RST_CYC+1). Default = T14, `loop_cycles`=14.
- Each extra cycle of stage latency adds 1 cycle.
- A new sample can be accepted in the same cycle `loop_done` is high.
- Timeout: a stage started at Ts with no done faults at Ts+TIMEOUT. `fault` is visible at Ts+TIMEOUT+1.

## Structure
- `foc_seq_pkg`: state enum (IDLE, START, WAIT, FLUSH, FAULT) and an overrun width constant (8).
- Sub-module `seq_timeout_ctr`: clear/enable timer with terminal-count flag, width $clog2(TIMEOUT). It is reused for the FLUSH hold.

## Test plan
- Defaults, all `stage_done` tied high, `valid` pulse at T0: `stage_start` is one-hot walking 1,2,4,…,32 at T1,T3,…,T11; `mod_rstb`=0 at T13; `loop_done` at T14; `loop_cycles`=14.
- `stage_done[2]` delayed 10 cycles: `loop_done` at T24, `loop_cycles`=24.
- `stage_done[3]` never asserts, TIMEOUT=512: `fault`=1, `fault_stage`=3, `mod_rstb`=0 held. `fault_clr` then gives `ready`=1 next cycle and no `loop_done`.
- `valid` held high continuously: one loop per 14 cycles, `overrun_cnt` increments 13 per loop and saturates at 255.
- `rstb` low during stage 4 WAIT: all outputs return to reset values asynchronously. After release, a new `valid` starts at stage 0.
- `stage_done[1]` and timeout land on the same cycle: no fault, sequence proceeds to stage 2.

Source files
------------

// File: rtl/foc_seq_pkg.sv
// Shared constants for the FOC control-loop sequencer: FSM encodings,
// overrun counter width and its saturating increment.
package foc_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int OVR_W = 8;

  function automatic logic [OVR_W-1:0] ovr_inc(input logic [OVR_W-1:0] v);
    return (v == {OVR_W{1'b1}}) ? v : v + {{(OVR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Clear/enable up-counter with a run-time terminal-count compare; shared by the
// stage watchdog and the end-of-loop flush hold.
module seq_timeout_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clear has priority over count
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/foc_seq.sv
// FOC control-loop sequencer: accepts a sample, walks the compute stages in order
// with a per-stage watchdog, then soft-resets the datapath before going idle.
module foc_seq
  import foc_seq_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int TIMEOUT    = 512,
  parameter int RST_CYC    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          valid,
  output logic                          ready,
  output logic                          cap_en,
  output logic [NUM_STAGES-1:0]         stage_start,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic                          mod_rstb,
  output logic                          loop_done,
  output logic [CNT_W-1:0]              loop_cycles,
  output logic [OVR_W-1:0]              overrun_cnt,
  output logic                          fault,
  output logic [$clog2(NUM_STAGES)-1:0] fault_stage,
  input  logic                          fault_clr
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam int TMR_W = $clog2(TIMEOUT);

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc_s;
  logic [CNT_W-1:0]      loop_cycles_q, loop_cycles_d;
  logic [OVR_W-1:0]      overrun_q, overrun_d;
  logic [IDX_W-1:0]      fault_stage_q, fault_stage_d;
  logic                  ready_q, ready_d;
  logic                  cap_en_q, cap_en_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  mod_rstb_q, mod_rstb_d;
  logic                  loop_done_q, loop_done_d;
  logic                  fault_q, fault_d;

  logic                  accept_s;
  logic                  done_s;
  logic                  tmr_clr_s, tmr_en_s, tmr_tc_s;
  logic [TMR_W-1:0]      tmr_term_s;

  // Watchdog in WAIT; the same counter times the mod_rstb low phase in FLUSH.
  seq_timeout_ctr #(.W(TMR_W)) u_tmr (
    .clk    (clk),
    .rstb   (rstb),
    .clr_i  (tmr_clr_s),
    .en_i   (tmr_en_s),
    .term_i (tmr_term_s),
    .tc_o   (tmr_tc_s)
  );

  assign accept_s  = valid && ready_q;
  assign done_s    = stage_done[idx_q];
  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // next-state and next-output logic; outputs are derived from the next state
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    loop_cycles_d = loop_cycles_q;
    fault_stage_d = fault_stage_q;
    loop_done_d   = 1'b0;
    tmr_clr_s     = 1'b0;
    tmr_en_s      = 1'b0;
    tmr_term_s    = TMR_W'(TIMEOUT - 1);
    overrun_d     = (valid && !ready_q) ? ovr_inc(overrun_q) : overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_START;
          idx_d   = '0;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_d     = cnt_inc_s;
        tmr_clr_s = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        // done is checked first so it beats a same-cycle timeout
        if (done_s) begin
          tmr_clr_s = 1'b1;
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = ST_FLUSH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_START;
          end
        end else if (tmr_tc_s) begin
          fault_stage_d = idx_q;
          state_d       = ST_FAULT;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        cnt_d      = cnt_inc_s;
        tmr_term_s = TMR_W'(RST_CYC - 1);
        if (tmr_tc_s) begin
          loop_cycles_d = cnt_inc_s;
          loop_done_d   = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d       = (state_d == ST_IDLE);
    cap_en_d      = accept_s;
    mod_rstb_d    = !((state_d == ST_FLUSH) || (state_d == ST_FAULT));
    fault_d       = (state_d == ST_FAULT);
    stage_start_d = (state_d == ST_START) ? ({{(NUM_STAGES-1){1'b0}}, 1'b1} << idx_d)
                                          : '0;
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      loop_cycles_q <= '0;
      overrun_q     <= '0;
      fault_stage_q <= '0;
      ready_q       <= 1'b1;
      cap_en_q      <= 1'b0;
      stage_start_q <= '0;
      mod_rstb_q    <= 1'b1;
      loop_done_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      loop_cycles_q <= loop_cycles_d;
      overrun_q     <= overrun_d;
      fault_stage_q <= fault_stage_d;
      ready_q       <= ready_d;
      cap_en_q      <= cap_en_d;
      stage_start_q <= stage_start_d;
      mod_rstb_q    <= mod_rstb_d;
      loop_done_q   <= loop_done_d;
      fault_q       <= fault_d;
    end
  end

  assign ready       = ready_q;
  assign cap_en      = cap_en_q;
  assign stage_start = stage_start_q;
  assign mod_rstb    = mod_rstb_q;
  assign loop_done   = loop_done_q;
  assign loop_cycles = loop_cycles_q;
  assign overrun_cnt = overrun_q;
  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;

endmodule
